// File: rtl/riscv_lsu.sv
// Load-store unit: turns core byte/half/word requests into word-addressed, byte-enabled bus accesses.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses without touching the bus.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        bus_err_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [2:0]  lat_size;
    logic [1:0]  lat_off;
    logic [31:0] rd_word;
    logic [31:0] timer;

    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic        misaligned;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane placement of the incoming request; unknown sizes behave as a full word.
    always_comb begin
        req_be = 4'b1111;
        req_wd = core_wd_i;
        case (core_size_i)
            3'd0, 3'd4: begin
                req_be = 4'b0001 << core_addr_i[1:0];
                req_wd = {4{core_wd_i[7:0]}};
            end
            3'd1, 3'd5: begin
                req_be = 4'b0011 << {core_addr_i[1], 1'b0};
                req_wd = {2{core_wd_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (core_size_i)
            3'd0, 3'd4: misaligned = 1'b0;
            3'd1, 3'd5: misaligned = core_addr_i[0];
            default:    misaligned = (core_addr_i[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign core_stall_o = !rst_i && core_req_i && (state != DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            lat_size   <= 3'd0;
            lat_off    <= 2'd0;
            rd_word    <= 32'd0;
            timer      <= 32'd0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'd0;
            mem_addr_o <= 32'd0;
            mem_wd_o   <= 32'd0;
            bus_err_o  <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req_i) begin
                        lat_size   <= core_size_i;
                        lat_off    <= core_addr_i[1:0];
                        mem_we_o   <= core_we_i;
                        mem_be_o   <= req_be;
                        mem_addr_o <= {core_addr_i[31:2], 2'b00};
                        mem_wd_o   <= req_wd;
                        timer      <= 32'd0;
                        if (misaligned) begin
                            rd_word    <= 32'd0;
                            misalign_o <= 1'b1;
                            state      <= DONE;
                        end else begin
                            mem_req_o <= 1'b1;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A ready arriving on the timeout cycle still completes the access.
                    if (mem_ready_i) begin
                        if (!mem_we_o) begin
                            rd_word <= mem_rd_i;
                        end
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (timer == 32'(TIMEOUT_CYCLES - 1))) begin
                        mem_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        rd_word   <= 32'd0;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                DONE: begin
                    bus_err_o  <= 1'b0;
                    misalign_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sel_byte = rd_word[7:0];
        case (lat_off)
            2'd0: sel_byte = rd_word[7:0];
            2'd1: sel_byte = rd_word[15:8];
            2'd2: sel_byte = rd_word[23:16];
            2'd3: sel_byte = rd_word[31:24];
            default: ;
        endcase
        sel_half = lat_off[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        core_rd_o = rd_word;
        case (lat_size)
            3'd0: core_rd_o = {{24{sel_byte[7]}}, sel_byte};
            3'd4: core_rd_o = {24'd0, sel_byte};
            3'd1: core_rd_o = {{16{sel_half[15]}}, sel_half};
            3'd5: core_rd_o = {16'd0, sel_half};
            default: core_rd_o = rd_word;
        endcase
    end

endmodule
